// File: rtl/vga_fb_pkg.sv
// Shared constants, types and the NES 2C02 palette (RGB333) for the VGA frame buffer.
package vga_fb_pkg;

    localparam int FB_W     = 256;
    localparam int FB_H     = 240;
    localparam int IDX_W    = 6;
    localparam int RGB_W    = 9;
    localparam int FB_DEPTH = FB_W * FB_H;

    localparam logic [7:0] FB_H_LIMIT = 8'(FB_H);

    typedef logic [IDX_W-1:0] pal_idx_t;
    typedef logic [RGB_W-1:0] rgb333_t;

    // Each entry is {R[2:0], G[2:0], B[2:0]}: the top 3 bits of the 8-bit 2C02 channel values.
    localparam rgb333_t NES_PALETTE [64] = '{
        9'h0DB, 9'h007, 9'h005, 9'h084, 9'h104, 9'h141, 9'h140, 9'h100,
        9'h088, 9'h018, 9'h018, 9'h010, 9'h012, 9'h000, 9'h000, 9'h000,
        9'h16D, 9'h01F, 9'h017, 9'h0D7, 9'h186, 9'h1C2, 9'h140, 9'h1D0,
        9'h158, 9'h028, 9'h028, 9'h02A, 9'h024, 9'h000, 9'h000, 9'h000,
        9'h1FF, 9'h06F, 9'h0E7, 9'h11F, 9'h1DF, 9'h1D4, 9'h1DA, 9'h1EA,
        9'h1E8, 9'h178, 9'h0B2, 9'h0BC, 9'h03E, 9'h0DB, 9'h000, 9'h000,
        9'h1FF, 9'h17F, 9'h16F, 9'h1AF, 9'h1EF, 9'h1EE, 9'h1F5, 9'h1FD,
        9'h1F3, 9'h1BB, 9'h17D, 9'h17E, 9'h03F, 9'h1F7, 9'h000, 9'h000
    };

    function automatic logic [15:0] fb_addr(input logic [7:0] y, input logic [7:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_fb_nes_palette_lut.sv
// Combinational palette index to RGB333 lookup.
module nes_palette_lut
    import vga_fb_pkg::*;
(
    input  pal_idx_t idx_i,
    output rgb333_t  rgb_o
);

    assign rgb_o = NES_PALETTE[idx_i];

endmodule

// File: rtl/vga_fb.sv
// 256x240 frame buffer: PPU write port, VGA registered read port with palette conversion.
module vga_fb
    import vga_fb_pkg::*;
(
    input  logic             pix_clk,
    input  logic             rst_n,
    input  logic [7:0]       ppu_ptr_x,
    input  logic [7:0]       ppu_ptr_y,
    input  logic [IDX_W-1:0] ppu_DI,
    input  logic             CS,
    input  logic [7:0]       pix_ptr_x,
    input  logic [7:0]       pix_ptr_y,
    output logic [RGB_W-1:0] rgb
);

    pal_idx_t    fb_mem [FB_DEPTH];

    logic        wr_en_s;
    logic [15:0] wr_addr_s;
    logic [15:0] rd_addr_s;
    logic        vis_d;
    logic        vis_q;
    pal_idx_t    idx_q;
    rgb333_t     lut_rgb_s;

    // Address decode; out-of-range lines neither write nor alias onto the array.
    always_comb begin
        wr_en_s   = CS && rst_n && (ppu_ptr_y < FB_H_LIMIT);
        wr_addr_s = fb_addr(ppu_ptr_y, ppu_ptr_x);
        vis_d     = (pix_ptr_y < FB_H_LIMIT);
        if (vis_d) begin
            rd_addr_s = fb_addr(pix_ptr_y, pix_ptr_x);
        end else begin
            rd_addr_s = 16'd0;
        end
    end

    // Write port.
    always_ff @(posedge pix_clk) begin
        if (wr_en_s) begin
            fb_mem[wr_addr_s] <= ppu_DI;
        end
    end

    // Registered read port; separate from the write block so a collision returns old data.
    always_ff @(posedge pix_clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            vis_q <= 1'b0;
        end else begin
            idx_q <= fb_mem[rd_addr_s];
            vis_q <= vis_d;
        end
    end

    nes_palette_lut u_lut (
        .idx_i (idx_q),
        .rgb_o (lut_rgb_s)
    );

    assign rgb = vis_q ? lut_rgb_s : {RGB_W{1'b0}};

endmodule

// File: tb/tb_vga_fb.sv
// Randomized and directed self-checking bench for vga_fb against a pixel-array model.
module tb_vga_fb;

    logic       pix_clk = 1'b0;
    logic       rst_n;
    logic [7:0] ppu_ptr_x, ppu_ptr_y, pix_ptr_x, pix_ptr_y;
    logic [5:0] ppu_DI;
    logic       CS;
    logic [8:0] rgb;

    int checks = 0;
    int errors = 0;

    logic [5:0] mdl_mem   [61440];
    bit         mdl_known [61440];

    // Full 8-bit-per-channel 2C02 colours; the frame buffer shows each channel's top 3 bits.
    localparam logic [23:0] RGB888 [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h440094, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hA81000, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    vga_fb dut (
        .pix_clk   (pix_clk),
        .rst_n     (rst_n),
        .ppu_ptr_x (ppu_ptr_x),
        .ppu_ptr_y (ppu_ptr_y),
        .ppu_DI    (ppu_DI),
        .CS        (CS),
        .pix_ptr_x (pix_ptr_x),
        .pix_ptr_y (pix_ptr_y),
        .rgb       (rgb)
    );

    always #5 pix_clk = ~pix_clk;

    function automatic logic [8:0] pal333(input logic [5:0] idx);
        int c, r, g, b;
        c = int'(RGB888[idx]);
        r = ((c / 65536) % 256) / 32;
        g = ((c / 256) % 256) / 32;
        b = (c % 256) / 32;
        return 9'((r * 64) + (g * 8) + b);
    endfunction

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, predict from the model (old contents), check, then commit the write.
    task automatic cycle(input int wx, input int wy, input int wd, input bit cs,
                         input int rx, input int ry, input bit rstn,
                         input string tag, output logic [8:0] got);
        bit         have_exp;
        logic [8:0] exp;
        have_exp = 1'b1;
        exp      = 9'h000;
        rst_n = rstn; CS = cs;
        ppu_ptr_x = 8'(wx); ppu_ptr_y = 8'(wy); ppu_DI = 6'(wd);
        pix_ptr_x = 8'(rx); pix_ptr_y = 8'(ry);
        if (rstn && ry < 240) begin
            if (mdl_known[ry * 256 + rx]) exp = pal333(mdl_mem[ry * 256 + rx]);
            else have_exp = 1'b0;
        end
        @(posedge pix_clk);
        #1;
        got = rgb;
        if (have_exp) check_eq(tag, got, exp);
        if (rstn && cs && wy < 240) begin
            mdl_mem[wy * 256 + wx]   = 6'(wd);
            mdl_known[wy * 256 + wx] = 1'b1;
        end
    endtask

    initial begin
        logic [8:0] got;
        for (int k = 0; k < 61440; k++) mdl_known[k] = 1'b0;
        rst_n = 1'b0; CS = 1'b0;
        ppu_ptr_x = 8'd0; ppu_ptr_y = 8'd0; ppu_DI = 6'd0;
        pix_ptr_x = 8'd0; pix_ptr_y = 8'd0;

        cycle(0, 0, 0, 1'b0, 0, 0, 1'b0, "reset0", got);
        cycle(0, 0, 0, 1'b0, 0, 0, 1'b0, "reset1", got);
        check_eq("reset_rgb", got, 9'h000);

        cycle(0, 23, 6'h03, 1'b1, 0, 0, 1'b1, "wr_0_23", got);
        cycle(0, 0, 0, 1'b0, 0, 23, 1'b1, "rd_0_23", got);
        check_eq("pix_0_23", got, 9'h084);

        for (int i = 0; i < 240; i++)
            for (int j = 0; j < 256; j++)
                cycle(j, i, (i + 6 * j) % 64, 1'b1, (j + 255) % 256, i, 1'b1, "sweep", got);

        cycle(10, 10, 6'h0F, 1'b1, 0, 0, 1'b1, "wr_10_10", got);
        cycle(10, 10, 6'h30, 1'b0, 0, 0, 1'b1, "cs_low_wr", got);
        cycle(0, 0, 0, 1'b0, 10, 10, 1'b1, "rd_10_10", got);
        check_eq("cs_low_no_write", got, 9'h000);

        cycle(5, 5, 6'h00, 1'b1, 0, 0, 1'b1, "wr_5_5", got);
        cycle(5, 5, 6'h16, 1'b1, 5, 5, 1'b1, "collide", got);
        check_eq("read_first_old", got, 9'h0DB);
        cycle(0, 0, 0, 1'b0, 5, 5, 1'b1, "after_collide", got);
        check_eq("read_new", got, 9'h140);

        cycle(0, 239, 6'h21, 1'b1, 0, 0, 1'b1, "wr_0_239", got);
        cycle(0, 240, 6'h30, 1'b1, 0, 0, 1'b1, "wr_0_240", got);
        cycle(0, 0, 0, 1'b0, 0, 239, 1'b1, "rd_0_239", got);
        check_eq("oor_write_dropped", got, pal333(6'h21));
        cycle(0, 0, 0, 1'b0, 0, 245, 1'b1, "rd_0_245", got);
        check_eq("oor_read_blank", got, 9'h000);

        cycle(7, 7, 6'h30, 1'b1, 0, 0, 1'b1, "wr_7_7", got);
        cycle(7, 7, 6'h01, 1'b1, 7, 7, 1'b0, "mid_reset0", got);
        check_eq("reset_blank0", got, 9'h000);
        cycle(7, 7, 6'h01, 1'b1, 7, 7, 1'b0, "mid_reset1", got);
        check_eq("reset_blank1", got, 9'h000);
        cycle(0, 0, 0, 1'b0, 7, 7, 1'b1, "post_reset", got);
        check_eq("mem_preserved", got, 9'h1FF);

        for (int n = 0; n < 3000; n++) begin
            cycle(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(63)),
                  bit'($urandom_range(1)), int'($urandom_range(255)), int'($urandom_range(255)),
                  ($urandom_range(63) != 0), "random", got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
